// File: rtl/counter_checker_pkg.sv
// Shared constants for the counter sequence checker: state encodings and
// default parameter values.
package counter_checker_pkg;

    localparam int DEFAULT_WIDTH        = 4;
    localparam int DEFAULT_LOCK_MATCHES = 2;
    localparam int DEFAULT_STALL_CYCLES = 16;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACQUIRE = 2'd1;
    localparam logic [STATE_W-1:0] ST_LOCKED  = 2'd2;

    localparam int ERR_COUNT_W = 8;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] value);
        if (value == {ERR_COUNT_W{1'b1}}) begin
            return value;
        end
        return value + ERR_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/counter_sequence_checker_stall_timer.sv
// Saturating idle-cycle counter. Counts while active and not restarted; the
// registered flag rises when the count reaches THRESHOLD.
module stall_timer #(
    parameter int THRESHOLD = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic active_in,
    input  logic restart_in,
    output logic stall_out
);

    localparam int CW = $clog2(THRESHOLD + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          stall_q;
    logic          stall_d;

    always_comb begin
        count_d = count_q;
        if (!active_in || restart_in) begin
            count_d = '0;
        end else if (count_q != CW'(THRESHOLD)) begin
            count_d = count_q + CW'(1);
        end
        // Flag tracks the next count so it drops in the same cycle the count restarts.
        stall_d = (count_d == CW'(THRESHOLD));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign stall_out = stall_q;

endmodule

// File: rtl/counter_sequence_checker.sv
// Watches a free-running count bus, locks onto it after consecutive correct
// increments, then flags sequence errors and stalls. There is no handshake:
// every output is a registered level updated one cycle after data_in is sampled.
module counter_sequence_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int LOCK_MATCHES = DEFAULT_LOCK_MATCHES,
    parameter int STALL_CYCLES = DEFAULT_STALL_CYCLES
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   enable_in,
    input  logic                   clear_in,
    output logic                   locked_out,
    output logic                   error_out,
    output logic [ERR_COUNT_W-1:0] err_count_out,
    output logic [WIDTH-1:0]       expected_out,
    output logic                   stall_out,
    output logic [STATE_W-1:0]     state_out
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [WIDTH-1:0]       prev_q, prev_d;
    logic [WIDTH-1:0]       expected_q, expected_d;
    logic [MW-1:0]          match_q, match_d;
    logic                   miss_q, miss_d;
    logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;
    logic                   error_q, error_d;

    logic                   change;
    logic [WIDTH-1:0]       data_plus1;
    logic [MW-1:0]          match_inc;

    assign change     = (data_in != prev_q);
    assign data_plus1 = data_in + WIDTH'(1);
    assign match_inc  = match_q + MW'(1);

    always_comb begin
        state_d     = state_q;
        prev_d      = data_in;
        expected_d  = expected_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_count_d = err_count_q;
        error_d     = 1'b0;

        if (!enable_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ACQUIRE;
                    expected_d = data_plus1;
                    match_d    = '0;
                end
                ST_ACQUIRE: begin
                    if (change) begin
                        expected_d = data_plus1;
                        if (data_in == expected_q) begin
                            match_d = match_inc;
                            if (match_inc == MW'(LOCK_MATCHES)) begin
                                state_d = ST_LOCKED;
                                miss_d  = 1'b0;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (change) begin
                        // Resync on every change so a single glitch costs one error.
                        expected_d = data_plus1;
                        if (data_in == expected_q) begin
                            miss_d = 1'b0;
                        end else begin
                            error_d     = 1'b1;
                            err_count_d = sat_inc(err_count_q);
                            if (miss_q) begin
                                state_d = ST_ACQUIRE;
                                match_d = '0;
                                miss_d  = 1'b0;
                            end else begin
                                miss_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (clear_in) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            expected_q  <= '0;
            match_q     <= '0;
            miss_q      <= 1'b0;
            err_count_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            expected_q  <= expected_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_count_q <= err_count_d;
            error_q     <= error_d;
        end
    end

    stall_timer #(
        .THRESHOLD (STALL_CYCLES)
    ) u_stall_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .active_in  (state_d == ST_LOCKED),
        .restart_in (change),
        .stall_out  (stall_out)
    );

    assign locked_out    = (state_q == ST_LOCKED);
    assign error_out     = error_q;
    assign err_count_out = err_count_q;
    assign expected_out  = expected_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Bench for counter_sequence_checker: directed scenarios plus random traffic,
// checked every cycle against a behavioural model through an expected queue.
module tb_counter_sequence_checker;
    import counter_checker_pkg::*;

    localparam int WIDTH        = 4;
    localparam int LOCK_MATCHES = 2;
    localparam int STALL_CYCLES = 16;
    localparam int M            = 1 << WIDTH;
    localparam int EW           = 2 + 1 + 1 + 8 + WIDTH + 1;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic             rst_in;
    logic [WIDTH-1:0] data_in;
    logic             enable_in;
    logic             clear_in;
    logic             locked_out;
    logic             error_out;
    logic [7:0]       err_count_out;
    logic [WIDTH-1:0] expected_out;
    logic             stall_out;
    logic [1:0]       state_out;

    counter_sequence_checker #(
        .WIDTH        (WIDTH),
        .LOCK_MATCHES (LOCK_MATCHES),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .data_in       (data_in),
        .enable_in     (enable_in),
        .clear_in      (clear_in),
        .locked_out    (locked_out),
        .error_out     (error_out),
        .err_count_out (err_count_out),
        .expected_out  (expected_out),
        .stall_out     (stall_out),
        .state_out     (state_out)
    );

    // ---------------- behavioural model ----------------
    bit m_active, m_locked, m_err;
    int m_prev, m_exp, m_run, m_miss, m_errs, m_quiet;

    task automatic model_step(input bit r, input bit e, input bit c, input int d);
        bit change;
        m_err = 1'b0;
        if (r) begin
            m_active = 0; m_locked = 0; m_prev = 0; m_exp = 0;
            m_run = 0; m_miss = 0; m_errs = 0; m_quiet = 0;
            return;
        end
        change = (d != m_prev);
        m_prev = d;
        if (!e) begin
            m_active = 0;
            m_locked = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_exp    = (d + 1) % M;
            m_run    = 0;
        end else if (!m_locked) begin
            if (change) begin
                m_run = (d == m_exp) ? m_run + 1 : 0;
                m_exp = (d + 1) % M;
                if (m_run >= LOCK_MATCHES) begin
                    m_locked = 1;
                    m_miss   = 0;
                    m_quiet  = 0;
                end
            end
        end else begin
            if (change) begin
                m_quiet = 0;
                if (d != m_exp) begin
                    m_err = 1'b1;
                    if (m_errs < 255) m_errs++;
                    m_miss++;
                    if (m_miss >= 2) begin
                        m_locked = 0;
                        m_run    = 0;
                        m_miss   = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = (d + 1) % M;
            end else if (m_quiet < STALL_CYCLES) begin
                m_quiet++;
            end
        end
        if (c) m_errs = 0;
    endtask

    function automatic logic [EW-1:0] model_outputs();
        logic [1:0]       st;
        logic [7:0]       ec;
        logic [WIDTH-1:0] ex;
        logic             stl;
        st  = m_locked ? ST_LOCKED : (m_active ? ST_ACQUIRE : ST_IDLE);
        ec  = m_errs[7:0];
        ex  = m_exp[WIDTH-1:0];
        stl = m_locked && (m_quiet >= STALL_CYCLES);
        return {st, m_locked, m_err, ec, ex, stl};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("state",     16'(state_out),     16'(mon_exp[EW-1 -: 2]));
            check("locked",    16'(locked_out),    16'(mon_exp[EW-3]));
            check("error",     16'(error_out),     16'(mon_exp[EW-4]));
            check("err_count", 16'(err_count_out), 16'(mon_exp[EW-5 -: 8]));
            check("expected",  16'(expected_out),  16'(mon_exp[WIDTH:1]));
            check("stall",     16'(stall_out),     16'(mon_exp[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit e, input bit c, input int d);
        rst_in    = r;
        enable_in = e;
        clear_in  = c;
        data_in   = WIDTH'(d);
        model_step(r, e, c, d);
        @(posedge clk_in);
        exp_q.push_back(model_outputs());
        #1;
    endtask

    task automatic run_seq(input int first, input int count);
        for (int i = 0; i < count; i++) drive(0, 1, 0, (first + i) % M);
    endtask

    task automatic hold(input int d, input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, d);
    endtask

    int seq_a[] = '{2, 3, 4, 5, 6, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 9, 3, 4, 5, 6, 7};
    int cur;
    int k;

    initial begin
        rst_in = 1'b1; enable_in = 1'b0; clear_in = 1'b0; data_in = '0;
        @(posedge clk_in); #1;

        drive(1, 0, 0, 0);
        drive(1, 1, 1, 5);                  // reset wins over enable and clear

        for (int v = 0; v < 4; v++) hold(v, 2);  // acquire and lock
        run_seq(4, 9);                      // 4..12
        run_seq(13, 5);                     // 13,14,15,0,1 wrap
        foreach (seq_a[i]) drive(0, 1, 0, seq_a[i]);
        hold(7, 18);                        // stall while locked
        drive(0, 1, 0, 8);
        run_seq(9, 4);
        drive(1, 1, 0, 3);                  // mid-operation reset with errors counted
        drive(0, 0, 0, 3);

        // Relock, then clear in the same cycle as an error.
        run_seq(0, 5);
        drive(0, 1, 1, 9);
        run_seq(10, 3);
        drive(0, 0, 0, 13);                 // enable drop from LOCKED
        run_seq(14, 6);

        // Alternating glitch/correct stays locked and drives the count to saturation.
        cur = 3;
        for (int i = 0; i < 262; i++) begin
            cur = (cur + 3) % M;
            drive(0, 1, 0, cur);
            cur = (cur + 1) % M;
            drive(0, 1, 0, cur);
        end

        // Random traffic.
        cur = 0;
        for (int i = 0; i < 700; i++) begin
            k = $urandom_range(0, 19);
            if (k < 12)      cur = (cur + 1) % M;
            else if (k < 17) cur = cur;
            else             cur = $urandom_range(0, M - 1);
            if ($urandom_range(0, 149) == 0) hold(cur, $urandom_range(14, 20));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) != 0,
                  $urandom_range(0, 59) == 0, cur);
        end

        repeat (3) @(posedge clk_in);
        check("drain", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
